wb_timeout_bridge: RTL and testbench
====================================

# wb_timeout_bridge

Registered single-outstanding Wishbone bridge placed directly upstream of the peripheral subsystem's slave port. It decouples system-bus timing from the subsystem's register interconnect and guarantees every access terminates. A transfer the downstream side does not terminate within a bounded number of cycles is aborted and answered with ERR, so a hung peripheral cannot stall the CPU.

## Interface
Parameters:
- WB_ADDR_WIDTH, 32, address width of both ports
- WB_DATA_WIDTH, 32, data width of both ports
- TIMEOUT_CYCLES, 64, max cycles m.STB is held without ACK/ERR; 0 disables the timeout

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- s  wb_if.slave  —  upstream side (system bus); uses ADR, DAT_W, DAT_R, SEL, WE, CYC, STB, ACK, ERR
- m  wb_if.master  —  downstream side (subsystem slave port)
- busy_o  output  1  high while a transfer is in flight (state != IDLE)
- timeout_o  output  1  one-cycle pulse when a timeout ERR is issued

## Operation
- FSM states:
  - IDLE: s.ACK=s.ERR=0, m.CYC=m.STB=0.
    - On s.CYC&s.STB: capture ADR, DAT_W, SEL and WE; clear the counter; go to REQ.
  - REQ: m.CYC=m.STB=1, driving the captured fields. Exits, highest priority first:
    - s.CYC=0 (upstream abort): go to IDLE; no response.
    - m.ERR=1: go to RESP with err flag set.
    - m.ACK=1: capture m.DAT_R; go to RESP.
    - Counter reaches TIMEOUT_CYCLES-1 (with TIMEOUT_CYCLES != 0): go to RESP with err flag and timeout flag set.
    - Otherwise: counter increments.
  - RESP: m.CYC=m.STB=0.
    - Assert s.ACK (or s.ERR if err flag) for exactly one cycle, with s.DAT_R = captured data (0 on any ERR).
    - Then go to IDLE.
- ACK and ERR in the same cycle: ERR wins.
- ACK in the same cycle the counter hits the limit: ACK wins, no timeout.
- Late m.ACK/m.ERR arriving while not in REQ is ignored.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1. Counter saturates and never wraps.
- Reset mid-transfer: immediate return to IDLE. All outputs deassert; the transfer is lost and no response is issued.

## Timing
- Reset values:
  - All s and m outputs 0.
  - busy_o=0, timeout_o=0.
  - Capture registers 0, counter 0.
- All outputs are registered; there is no combinational path from s to m or from m to s.
- Request seen at cycle 0 → m.STB=1 at cycle 1.
- m.ACK at cycle k → s.ACK at k+1 → IDLE at k+2. A new request is accepted at k+2.
- Zero-wait downstream: 3 cycles per transfer.
- Timeout: m.STB is high for exactly TIMEOUT_CYCLES cycles. s.ERR and timeout_o are asserted on the following cycle.
- s.STB is expected to hold until ACK/ERR (classic cycle). The bridge does not re-sample s fields after capture.

## Configuration
- WB_TIMEOUT_BRIDGE_ERR_CAPTURE_EN, when defined:
  - Adds ports err_addr_o (output, WB_ADDR_WIDTH), err_valid_o (output, 1) and err_clr_i (input, 1).
  - On any ERR response (downstream or timeout), err_addr_o latches the captured address and err_valid_o sets, sticky.
  - err_clr_i=1 clears err_valid_o the next cycle. If an ERR and a clear occur in the same cycle, the set wins.
  - Both outputs reset to 0.
- When not defined: these ports and their registers do not exist; all other behaviour is identical.

## Structure
- Package wb_timeout_bridge_pkg holds the state enum (IDLE, REQ, RESP) and a function computing the counter width from TIMEOUT_CYCLES.
- Single module with no sub-modules; the counter is inline.

## Test plan
- Zero-wait read at ADR=0x404 with downstream DAT_R=0xA5A5_0001 → s.ACK is asserted at cycle 3 after the request with s.DAT_R=0xA5A5_0001; m.STB is high for 1 cycle.
- Write DAT_W=0x1234_5678, SEL=0xF, with 5 downstream wait states → m holds the captured fields for 6 cycles; s.ACK pulses once; busy_o falls the cycle after.
- TIMEOUT_CYCLES=8, downstream never acks → m.STB high exactly 8 cycles, then s.ERR=1 and timeout_o=1 for one cycle, s.DAT_R=0. A late m.ACK 3 cycles later is ignored.
- Downstream asserts ACK and ERR together → s.ERR only. ACK arriving exactly on the 8th STB cycle → s.ACK, timeout_o stays 0.
- Upstream drops s.CYC after 2 REQ cycles → m.CYC falls the next cycle, no s.ACK/ERR. rst pulsed mid-REQ → all outputs 0 immediately, and the next request is served normally.
- With WB_TIMEOUT_BRIDGE_ERR_CAPTURE_EN: timeout at ADR=0x44C → err_addr_o=0x44C, err_valid_o=1 and remains set; err_clr_i pulse → 0 the next cycle.

Source files
------------

// File: rtl/wb_timeout_bridge_pkg.sv
// Shared types and helpers for the Wishbone timeout bridge.
package wb_timeout_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2
    } state_e;

    // Counter must hold 0..TIMEOUT_CYCLES; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
        int unsigned w;
        w = $clog2(timeout_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_if.sv
// Classic Wishbone bus bundle with master/slave views.
interface wb_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   ADR;
    logic [DATA_WIDTH-1:0]   DAT_W;
    logic [DATA_WIDTH-1:0]   DAT_R;
    logic [DATA_WIDTH/8-1:0] SEL;
    logic                    WE;
    logic                    CYC;
    logic                    STB;
    logic                    ACK;
    logic                    ERR;

    modport master (
        output ADR, DAT_W, SEL, WE, CYC, STB,
        input  DAT_R, ACK, ERR
    );

    modport slave (
        input  ADR, DAT_W, SEL, WE, CYC, STB,
        output DAT_R, ACK, ERR
    );
endinterface

// File: rtl/wb_timeout_bridge.sv
// Registered single-outstanding Wishbone bridge that answers hung downstream transfers with ERR.
// Optional error-address capture is enabled by defining WB_TIMEOUT_BRIDGE_ERR_CAPTURE_EN.
module wb_timeout_bridge
    import wb_timeout_bridge_pkg::*;
#(
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    wb_if.slave                      s,
    wb_if.master                     m,
`ifdef WB_TIMEOUT_BRIDGE_ERR_CAPTURE_EN
    output logic [WB_ADDR_WIDTH-1:0] err_addr_o,
    output logic                     err_valid_o,
    input  logic                     err_clr_i,
`endif
    output logic                     busy_o,
    output logic                     timeout_o
);

    localparam int unsigned SelWidth  = WB_DATA_WIDTH / 8;
    localparam int unsigned CntWidth  = cnt_width(TIMEOUT_CYCLES);
    localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam logic [CntWidth-1:0] CntMax   = '1;
    localparam logic [CntWidth-1:0] CntLimit =
        TimeoutEn ? CntWidth'(TIMEOUT_CYCLES - 1) : '0;

    state_e                   state_q, state_d;
    logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0] dat_w_q, dat_w_d;
    logic [SelWidth-1:0]      sel_q, sel_d;
    logic                     we_q, we_d;
    logic [CntWidth-1:0]      cnt_q, cnt_d;
    logic [WB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic                     timeout_q, timeout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            adr_q     <= '0;
            dat_w_q   <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_w_q   <= dat_w_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_w_d   = dat_w_q;
        sel_d     = sel_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (s.CYC && s.STB) begin
                    adr_d     = s.ADR;
                    dat_w_d   = s.DAT_W;
                    sel_d     = s.SEL;
                    we_d      = s.WE;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = StReq;
                end
            end
            StReq: begin
                // Exit priority: abort, downstream ERR, ACK, then timeout.
                if (!s.CYC) begin
                    state_d = StIdle;
                end else if (m.ERR) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StResp;
                end else if (m.ACK) begin
                    rdata_d = m.DAT_R;
                    state_d = StResp;
                end else if (TimeoutEn && (cnt_q == CntLimit)) begin
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    rdata_d   = '0;
                    state_d   = StResp;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Every output decodes straight from flops; nothing passes combinationally across.
    assign m.CYC   = (state_q == StReq);
    assign m.STB   = (state_q == StReq);
    assign m.ADR   = adr_q;
    assign m.DAT_W = dat_w_q;
    assign m.SEL   = sel_q;
    assign m.WE    = we_q;

    assign s.ACK   = (state_q == StResp) && !err_q;
    assign s.ERR   = (state_q == StResp) && err_q;
    assign s.DAT_R = rdata_q;

    assign busy_o    = (state_q != StIdle);
    assign timeout_o = (state_q == StResp) && timeout_q;

`ifdef WB_TIMEOUT_BRIDGE_ERR_CAPTURE_EN
    logic [WB_ADDR_WIDTH-1:0] err_addr_q;
    logic                     err_valid_q;
    logic                     err_set;

    assign err_set = (state_q == StReq) && (state_d == StResp) && err_d;

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_addr_q  <= '0;
            err_valid_q <= 1'b0;
        end else if (err_set) begin
            err_addr_q  <= adr_q;
            err_valid_q <= 1'b1;
        end else if (err_clr_i) begin
            err_valid_q <= 1'b0;
        end
    end

    assign err_addr_o  = err_addr_q;
    assign err_valid_o = err_valid_q;
`endif

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Scoreboard bench for wb_timeout_bridge with TIMEOUT_CYCLES=8 and a scripted downstream slave.
module tb_wb_timeout_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();
    wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_bus ();

    logic busy;
    logic timeout;
`ifdef WB_TIMEOUT_BRIDGE_ERR_CAPTURE_EN
    logic [AW-1:0] err_addr;
    logic          err_valid;
    logic          err_clr = 1'b0;
`endif

    wb_timeout_bridge #(
        .WB_ADDR_WIDTH (AW),
        .WB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (s_bus),
        .m          (m_bus),
`ifdef WB_TIMEOUT_BRIDGE_ERR_CAPTURE_EN
        .err_addr_o (err_addr),
        .err_valid_o(err_valid),
        .err_clr_i  (err_clr),
`endif
        .busy_o     (busy),
        .timeout_o  (timeout)
    );

    // Downstream slave: answers after ds_wait STB cycles when enabled.
    bit          ds_ack_en = 1'b0;
    bit          ds_err_en = 1'b0;
    bit          late_ack  = 1'b0;
    int          ds_wait   = 0;
    logic [31:0] ds_rdata  = '0;
    int          stb_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst || !m_bus.STB) stb_cnt <= 0;
        else                   stb_cnt <= stb_cnt + 1;
    end

    assign m_bus.ACK   = (m_bus.STB && ds_ack_en && (stb_cnt == ds_wait)) || late_ack;
    assign m_bus.ERR   = m_bus.STB && ds_err_en && (stb_cnt == ds_wait);
    assign m_bus.DAT_R = ds_rdata;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat_w;
        logic [3:0]  sel;
        logic        we;
        int          len;  // expected STB cycles; 0 = not checked
    } req_t;

    typedef struct {
        logic        ack;
        logic        err;
        logic        to;
        logic [31:0] data;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Monitor: checks downstream request fields/length and upstream responses.
    initial begin : monitor
        int   run;
        bit   prev;
        req_t r;
        rsp_t e;
        run  = 0;
        prev = 1'b0;
        @(negedge rst);
        forever begin
            @(negedge clk);
            if (m_bus.STB) begin
                if (req_q.size() > 0) begin
                    r = req_q[0];
                    chk("m_fields", {m_bus.ADR, m_bus.DAT_W, m_bus.SEL, m_bus.WE},
                        {r.adr, r.dat_w, r.sel, r.we});
                end
                chk("m_cyc_with_stb", m_bus.CYC, 1);
                run++;
            end else if (prev) begin
                if (req_q.size() > 0) begin
                    r = req_q.pop_front();
                    if (r.len != 0) chk("stb_len", run, r.len);
                end
                run = 0;
            end
            prev = m_bus.STB;

            if (s_bus.ACK || s_bus.ERR) begin
                chk("resp_pending", rsp_q.size() != 0, 1);
                if (rsp_q.size() != 0) begin
                    e = rsp_q.pop_front();
                    chk("resp", {s_bus.ACK, s_bus.ERR, timeout, s_bus.DAT_R},
                        {e.ack, e.err, e.to, e.data});
                    chk("busy_in_resp", busy, 1);
                end
            end else if (timeout) begin
                chk("stray_timeout", timeout, 0);
            end
        end
    end

    task automatic start_req(input logic [31:0] adr, input logic [31:0] dat, input logic we);
        @(posedge clk);
        #1;
        s_bus.ADR   = adr;
        s_bus.DAT_W = dat;
        s_bus.SEL   = 4'hF;
        s_bus.WE    = we;
        s_bus.CYC   = 1'b1;
        s_bus.STB   = 1'b1;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(s_bus.ACK || s_bus.ERR) && n < 40);
        chk("resp_seen", s_bus.ACK || s_bus.ERR, 1);
    endtask

    task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                        input int len, input rsp_t e, output int n);
        req_q.push_back('{adr: adr, dat_w: dat, sel: 4'hF, we: we, len: len});
        rsp_q.push_back(e);
        start_req(adr, dat, we);
        wait_resp(n);
        s_bus.CYC = 1'b0;
        s_bus.STB = 1'b0;
        @(negedge clk);
        chk("busy_after_resp", busy, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        s_bus.ADR   = '0;
        s_bus.DAT_W = '0;
        s_bus.SEL   = '0;
        s_bus.WE    = 1'b0;
        s_bus.CYC   = 1'b0;
        s_bus.STB   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ack_err", {s_bus.ACK, s_bus.ERR}, 0);
        chk("rst_s_dat_r", s_bus.DAT_R, 0);
        chk("rst_m_cyc_stb", {m_bus.CYC, m_bus.STB}, 0);
        chk("rst_m_fields", {m_bus.ADR, m_bus.DAT_W, m_bus.SEL, m_bus.WE}, 0);
        chk("rst_busy_timeout", {busy, timeout}, 0);
        rst = 1'b0;

        // Zero-wait read.
        ds_ack_en = 1'b1; ds_err_en = 1'b0; ds_wait = 0; ds_rdata = 32'hA5A5_0001;
        xfer(32'h404, 32'h0, 1'b0, 1, '{ack: 1, err: 0, to: 0, data: 32'hA5A5_0001}, n);
        chk("zero_wait_latency", n, 3);

        // Write with 5 wait states.
        ds_wait = 5; ds_rdata = 32'h0;
        xfer(32'h408, 32'h1234_5678, 1'b1, 6, '{ack: 1, err: 0, to: 0, data: 32'h0}, n);
        chk("wait5_latency", n, 8);

        // Timeout, then a late ACK.
        ds_ack_en = 1'b0; ds_rdata = 32'hFFFF_FFFF;
        xfer(32'h40C, 32'h0, 1'b0, TO, '{ack: 0, err: 1, to: 1, data: 32'h0}, n);
        chk("timeout_latency", n, TO + 2);
        repeat (2) @(posedge clk);
        #1 late_ack = 1'b1;
        @(negedge clk);
        chk("late_ack_ignored", {busy, s_bus.ACK, s_bus.ERR}, 0);
        @(posedge clk);
        #1 late_ack = 1'b0;

        // ACK and ERR together.
        ds_ack_en = 1'b1; ds_err_en = 1'b1; ds_wait = 2; ds_rdata = 32'hDEAD_BEEF;
        xfer(32'h414, 32'h0, 1'b0, 3, '{ack: 0, err: 1, to: 0, data: 32'h0}, n);

        // ACK on the last allowed STB cycle.
        ds_err_en = 1'b0; ds_wait = TO - 1; ds_rdata = 32'h0BAD_F00D;
        xfer(32'h418, 32'h0, 1'b0, TO, '{ack: 1, err: 0, to: 0, data: 32'h0BAD_F00D}, n);

        // Upstream abort after 2 REQ cycles.
        ds_ack_en = 1'b0;
        req_q.push_back('{adr: 32'h41C, dat_w: 32'h0, sel: 4'hF, we: 1'b0, len: 2});
        start_req(32'h41C, 32'h0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        s_bus.CYC = 1'b0;
        s_bus.STB = 1'b0;
        @(negedge clk);
        chk("abort_cyc_still_high", m_bus.CYC, 1);
        @(negedge clk);
        chk("abort_cyc_low", m_bus.CYC, 0);
        chk("abort_busy_low", busy, 0);
        repeat (3) @(negedge clk);

        // Reset mid-REQ.
        req_q.push_back('{adr: 32'h420, dat_w: 32'h0, sel: 4'hF, we: 1'b0, len: 0});
        start_req(32'h420, 32'h0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        s_bus.CYC = 1'b0;
        s_bus.STB = 1'b0;
        #1;
        chk("midrst_s_ack_err", {s_bus.ACK, s_bus.ERR}, 0);
        chk("midrst_m_cyc_stb", {m_bus.CYC, m_bus.STB}, 0);
        chk("midrst_busy_timeout", {busy, timeout}, 0);
        chk("midrst_m_adr", m_bus.ADR, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        ds_ack_en = 1'b1; ds_wait = 0; ds_rdata = 32'h5555_AAAA;
        xfer(32'h424, 32'h0, 1'b0, 1, '{ack: 1, err: 0, to: 0, data: 32'h5555_AAAA}, n);
        chk("post_rst_latency", n, 3);

`ifdef WB_TIMEOUT_BRIDGE_ERR_CAPTURE_EN
        ds_ack_en = 1'b0;
        xfer(32'h44C, 32'h0, 1'b0, TO, '{ack: 0, err: 1, to: 1, data: 32'h0}, n);
        chk("err_addr", err_addr, 32'h44C);
        chk("err_valid_set", err_valid, 1);
        repeat (3) @(negedge clk);
        chk("err_valid_sticky", err_valid, 1);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(negedge clk);
        chk("err_valid_before_clr", err_valid, 1);
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        chk("err_valid_cleared", err_valid, 0);
`endif

        repeat (4) @(negedge clk);
        chk("rsp_q_drained", rsp_q.size(), 0);
        chk("req_q_drained", req_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
